next_pc_unit: RTL

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/next_pc_unit_if.sv | 34 +++
 rtl/next_pc_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/next_pc_unit_if.sv
// Bundle of ID-stage redirect inputs and fetch-side outputs between the
// pipeline and the next-PC unit.
interface next_pc_unit_if;
    logic        stall;
    logic [2:0]  br_op;
    logic        equal;
    logic        greater;
    logic        less;
    logic [1:0]  jump_op;
    logic [31:0] id_pc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        taken;
    logic        if_bd;
    logic        if_adel;
    logic        if_flush;

    modport master (
        output stall, br_op, equal, greater, less, jump_op, id_pc,
               imm16, imm26, jr_target, exc_req, eret, epc,
        input  pc, taken, if_bd, if_adel, if_flush
    );

    modport slave (
        input  stall, br_op, equal, greater, less, jump_op, id_pc,
               imm16, imm26, jr_target, exc_req, eret, epc,
        output pc, taken, if_bd, if_adel, if_flush
    );
endinterface

// File: rtl/next_pc_unit.sv
// Fetch PC register with branch/jump resolution from ID, eret return and
// exception entry; flags delay slots, fetch address errors and IF flushes.
module next_pc_unit (
    input  logic           clk,
    input  logic           reset,
    next_pc_unit_if.slave  bus
);
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] ADDR_LO    = 32'h0000_3000;
    localparam logic [31:0] ADDR_HI    = 32'h0000_6FFC;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGTZ = 3'd3,
        BR_BLEZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_kind_t;

    logic [31:0] pc_q;
    logic [31:0] id_pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        branch_cond;
    logic        jump_taken;
    logic        taken;

    always_comb begin
        branch_cond = 1'b0;
        case (br_kind_t'(bus.br_op))
            BR_BEQ:  branch_cond = bus.equal;
            BR_BNE:  branch_cond = !bus.equal;
            BR_BGTZ: branch_cond = bus.greater;
            BR_BLEZ: branch_cond = !bus.greater;
            BR_BLTZ: branch_cond = bus.less;
            BR_BGEZ: branch_cond = !bus.less;
            default: branch_cond = 1'b0;
        endcase
    end

    assign jump_taken    = (bus.jump_op == 2'd1) || (bus.jump_op == 2'd2);
    assign taken         = branch_cond || jump_taken;
    assign id_pc_plus4   = bus.id_pc + 32'd4;
    assign branch_target = id_pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign jump_target   = {id_pc_plus4[31:28], bus.imm26, 2'b00};

    // Jumps only redirect when jump_op is valid, so they win over the branch path.
    always_comb begin
        redirect_target = branch_target;
        if (bus.jump_op == 2'd2)
            redirect_target = bus.jr_target;
        else if (bus.jump_op == 2'd1)
            redirect_target = jump_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= RESET_PC;
        else if (bus.exc_req)
            pc_q <= EXC_VECTOR;
        else if (bus.stall)
            pc_q <= pc_q;
        else if (bus.eret)
            pc_q <= bus.epc;
        else if (taken)
            pc_q <= redirect_target;
        else
            pc_q <= pc_q + 32'd4;
    end

    assign bus.pc       = pc_q;
    assign bus.taken    = taken;
    assign bus.if_bd    = (bus.br_op != 3'd0) || (bus.jump_op != 2'd0);
    assign bus.if_adel  = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);
    // Taken branches never flush: their delay slot in IF must execute.
    assign bus.if_flush = bus.eret && !bus.stall && !bus.exc_req;
endmodule
